// File: rtl/cs_resolve_if.sv
// Operand/result handshake bundle for cs_resolve.
// The master side drives operands and consumes results; the slave side is the resolver.
interface cs_resolve_if #(
  parameter int W  = 32,
  parameter int IW = $clog2(W + 3)
);
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_ps;
  logic [W-1:0]  in_pc;
  logic          out_valid;
  logic          out_ready;
  logic [W+1:0]  out_sum;
  logic [IW-1:0] out_iters;

  modport master (
    output in_valid, in_ps, in_pc, out_ready,
    input  in_ready, out_valid, out_sum, out_iters
  );

  modport slave (
    input  in_valid, in_ps, in_pc, out_ready,
    output in_ready, out_valid, out_sum, out_iters
  );
endinterface

// File: rtl/cs_resolve.sv
// Iterative carry-save to binary resolver: x ^= y, y = (x & y) << 1 until y is zero.
// Define CS_RESOLVE_PIPE_EN to let a new pair load on the same edge as the output handshake.
module cs_resolve #(
  parameter int W  = 32,
  parameter int IW = $clog2(W + 3)
) (
  input  logic       clk,
  input  logic       rst,
  cs_resolve_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RESOLVE, DONE} state_t;

  state_t        state_q, state_d;
  logic [W+1:0]  x_q, x_d;
  logic [W+1:0]  y_q, y_d;
  logic [IW-1:0] cnt_q, cnt_d;
  logic [W+1:0]  carry;
  logic          load;
  logic          in_ready_c;

  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    cnt_d      = cnt_q;
    in_ready_c = 1'b0;
    load       = 1'b0;
    carry      = (x_q & y_q) << 1;

    case (state_q)
      IDLE: begin
        in_ready_c = 1'b1;
        load       = bus.in_valid;
      end
      RESOLVE: begin
        // x + y is preserved each step, so the carry word drains to zero within W+2 steps
        x_d   = x_q ^ y_q;
        y_d   = carry;
        cnt_d = cnt_q + {{(IW-1){1'b0}}, 1'b1};
        if (carry == '0) begin
          state_d = DONE;
        end
      end
      DONE: begin
`ifdef CS_RESOLVE_PIPE_EN
        in_ready_c = bus.out_ready;
        if (bus.out_ready) begin
          if (bus.in_valid) begin
            load = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
`else
        if (bus.out_ready) begin
          state_d = IDLE;
        end
`endif
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      x_d     = {2'b00, bus.in_ps};
      y_d     = {1'b0, bus.in_pc, 1'b0};
      cnt_d   = '0;
      state_d = RESOLVE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = (state_q == DONE);
  assign bus.out_sum   = x_q;
  assign bus.out_iters = cnt_q;

endmodule

// File: tb/tb_cs_resolve.sv
// Directed-vector bench for cs_resolve: table of operand pairs plus
// backpressure, mid-flight reset and back-to-back sequences.
module tb_cs_resolve;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  cs_resolve_if #(.W(32)) bif ();

  cs_resolve #(.W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] ps;
    logic [31:0] pc;
    logic [33:0] sum;
    int          iters;
  } vec_t;

  vec_t vecs [10];

`ifdef CS_RESOLVE_PIPE_EN
  localparam logic PIPE_RDY = 1'b1;
`else
  localparam logic PIPE_RDY = 1'b0;
`endif

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge right after the accepting edge.
  task automatic accept_pair(input logic [31:0] ps, input logic [31:0] pc);
    int c = 0;
    bif.in_valid = 1'b1;
    bif.in_ps    = ps;
    bif.in_pc    = pc;
    while (!bif.in_ready && c < 100) begin
      @(negedge clk);
      c++;
    end
    chk("accept_timeout", 64'(c >= 100), 64'd0);
    @(posedge clk);
    @(negedge clk);
    bif.in_valid = 1'b0;
  endtask

  // Latency counted in rising edges after the accepting edge.
  task automatic collect(input logic [33:0] es, input int ei, input string nm);
    int lat = 0;
    while (!bif.out_valid && lat < 64) begin
      @(negedge clk);
      lat++;
    end
    chk({nm, "_timeout"}, 64'(lat >= 64), 64'd0);
    chk({nm, "_sum"}, 64'(bif.out_sum), 64'(es));
    chk({nm, "_iters"}, 64'(bif.out_iters), 64'(ei));
    chk({nm, "_latency"}, 64'(lat), 64'(ei));
    $display("txn %s: sum=0x%0h iters=%0d latency=%0d", nm, bif.out_sum, bif.out_iters, lat);
  endtask

  initial begin
    vecs[0] = '{32'd5,          32'd1,          34'h0_0000_0007, 1};
    vecs[1] = '{32'hFFFF_FFFF,  32'd1,          34'h1_0000_0001, 32};
    vecs[2] = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  34'h2_FFFF_FFFD, 3};
    vecs[3] = '{32'd0,          32'd0,          34'h0_0000_0000, 1};
    vecs[4] = '{32'd3,          32'd0,          34'h0_0000_0003, 1};
    vecs[5] = '{32'd1,          32'h8000_0000,  34'h1_0000_0001, 1};
    vecs[6] = '{32'h0000_000F,  32'd1,          34'h0_0000_0011, 4};
    vecs[7] = '{32'd2,          32'd3,          34'h0_0000_0008, 3};
    vecs[8] = '{32'h8000_0000,  32'h4000_0000,  34'h1_0000_0000, 2};
    vecs[9] = '{32'hFFFF_FFFF,  32'h8000_0000,  34'h1_FFFF_FFFF, 1};

    rst           = 1'b1;
    bif.in_valid  = 1'b0;
    bif.in_ps     = '0;
    bif.in_pc     = '0;
    bif.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 64'(bif.in_ready), 64'd1);
    chk("rst_out_valid", 64'(bif.out_valid), 64'd0);
    chk("rst_out_sum", 64'(bif.out_sum), 64'd0);
    chk("rst_out_iters", 64'(bif.out_iters), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      accept_pair(vecs[i].ps, vecs[i].pc);
      collect(vecs[i].sum, vecs[i].iters, $sformatf("vec%0d", i));
      @(negedge clk);
      chk($sformatf("vec%0d_valid_drop", i), 64'(bif.out_valid), 64'd0);
    end

    // Backpressure with the next pair held on the input
    bif.out_ready = 1'b0;
    accept_pair(32'd5, 32'd1);
    bif.in_valid = 1'b1;
    bif.in_ps    = 32'd2;
    bif.in_pc    = 32'd3;
    collect(34'd7, 1, "bp_first");
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("bp_hold_valid", 64'(bif.out_valid), 64'd1);
      chk("bp_hold_sum", 64'(bif.out_sum), 64'd7);
      chk("bp_hold_iters", 64'(bif.out_iters), 64'd1);
      chk("bp_hold_in_ready", 64'(bif.in_ready), 64'd0);
    end
    bif.out_ready = 1'b1;
    #1;
    chk("bp_release_in_ready", 64'(bif.in_ready), 64'(PIPE_RDY));
    accept_pair(32'd2, 32'd3);
    collect(34'd8, 3, "bp_second");
    @(negedge clk);

    // Reset during the 5th RESOLVE cycle of the 32-step ripple
    accept_pair(32'hFFFF_FFFF, 32'd1);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", 64'(bif.out_valid), 64'd0);
    chk("midrst_in_ready", 64'(bif.in_ready), 64'd1);
    @(negedge clk);
    rst = 1'b0;
    chk("postrst_in_ready", 64'(bif.in_ready), 64'd1);
    chk("postrst_out_sum", 64'(bif.out_sum), 64'd0);
    chk("postrst_out_iters", 64'(bif.out_iters), 64'd0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("postrst_no_valid", 64'(bif.out_valid), 64'd0);
    end
    accept_pair(32'd3, 32'd0);
    collect(34'd3, 1, "after_rst");
    @(negedge clk);

    // Back-to-back pairs with the consumer always ready
    accept_pair(32'd5, 32'd1);
    bif.in_valid = 1'b1;
    bif.in_ps    = 32'd2;
    bif.in_pc    = 32'd3;
    collect(34'd7, 1, "b2b_first");
    chk("b2b_in_ready_at_done", 64'(bif.in_ready), 64'(PIPE_RDY));
    accept_pair(32'd2, 32'd3);
    collect(34'd8, 3, "b2b_second");
    @(negedge clk);
    chk("b2b_valid_drop", 64'(bif.out_valid), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
